// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader
//   Assembles one 3x3 x 3x3 operand frame from a byte stream and hands it to the
//   downstream multiplier over a valid/ready handshake.
//   Frame on the wire: SYNC, 9 bytes of A, 9 bytes of B, then one checksum byte.
//   The checksum is the mod-256 sum of the 18 payload bytes.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   rx_data       received byte, qualified by rx_valid
//   rx_valid      one-cycle strobe for rx_data
//   a_flat        matrix A, row-major, element k at [8k+7:8k]
//   b_flat        matrix B, same packing
//   mat_valid     a_flat/b_flat hold a verified frame
//   mat_ready     consumer accepts the frame (transfer on mat_valid & mat_ready)
//   busy          a frame is being received (LOAD_A, LOAD_B or CHECK)
//   err_checksum  one-cycle pulse: checksum mismatch, frame dropped
//   err_timeout   one-cycle pulse: inter-byte gap too long, frame dropped
//   err_overrun   one-cycle pulse: byte arrived while a frame was waiting, byte dropped
//   frame_count   number of frames handed off, wraps at 256
module matrix_frame_loader #(
  parameter int              DATA_WIDTH     = 8,
  parameter logic [7:0]      SYNC_BYTE      = 8'hA5,
  parameter int              TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [9*DATA_WIDTH-1:0] a_flat,
  output logic [9*DATA_WIDTH-1:0] b_flat,
  output logic                    mat_valid,
  input  logic                    mat_ready,
  output logic                    busy,
  output logic                    err_checksum,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic [7:0]              frame_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;

  logic [2:0]              state;
  logic [3:0]              idx;
  logic [DATA_WIDTH-1:0]   sum;
  logic [TW-1:0]           tcnt;
  // Frames are assembled here so the visible buses only change on commit.
  logic [9*DATA_WIDTH-1:0] shadow_a;
  logic [9*DATA_WIDTH-1:0] shadow_b;

  assign busy = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      sum          <= '0;
      tcnt         <= '0;
      shadow_a     <= '0;
      shadow_b     <= '0;
      a_flat       <= '0;
      b_flat       <= '0;
      mat_valid    <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      frame_count  <= '0;
    end else begin
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= S_LOAD_A;
            idx   <= '0;
            sum   <= '0;
            tcnt  <= '0;
          end
        end

        S_LOAD_A, S_LOAD_B, S_CHECK: begin
          // A byte in the same cycle as the timeout wins, so test it first.
          if (rx_valid) begin
            tcnt <= '0;
            if (state == S_LOAD_A) begin
              shadow_a[{idx, 3'b000} +: 8] <= rx_data;
              sum <= sum + rx_data;
              if (idx == 4'd8) begin
                state <= S_LOAD_B;
                idx   <= '0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else if (state == S_LOAD_B) begin
              shadow_b[{idx, 3'b000} +: 8] <= rx_data;
              sum <= sum + rx_data;
              if (idx == 4'd8) begin
                state <= S_CHECK;
                idx   <= '0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              if (rx_data == sum) begin
                a_flat    <= shadow_a;
                b_flat    <= shadow_b;
                mat_valid <= 1'b1;
                state     <= S_READY;
              end else begin
                err_checksum <= 1'b1;
                state        <= S_IDLE;
              end
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // This idle cycle brings the gap to TIMEOUT_CYCLES.
            err_timeout <= 1'b1;
            tcnt        <= '0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_READY: begin
          if (mat_ready) begin
            mat_valid   <= 1'b0;
            frame_count <= frame_count + 8'd1;
            state       <= S_IDLE;
            // The handshake frees the loader this cycle, so a byte arriving
            // now is treated exactly as it would be in IDLE.
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state <= S_LOAD_A;
              idx   <= '0;
              sum   <= '0;
              tcnt  <= '0;
            end
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// tb_matrix_frame_loader
//   Directed bench for matrix_frame_loader with a short timeout (16 cycles).
//   Frames and their checksums are hand-computed constants.
module tb_matrix_frame_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [71:0] a_flat;
  logic [71:0] b_flat;
  logic        mat_valid;
  logic        mat_ready;
  logic        busy;
  logic        err_checksum;
  logic        err_timeout;
  logic        err_overrun;
  logic [7:0]  frame_count;

  int total = 0;
  int bad   = 0;

  // Frame 1: A = 01..09, B = 09..01, sum 90 = 0x5A
  localparam logic [71:0] FA1 = 72'h090807060504030201;
  localparam logic [71:0] FB1 = 72'h010203040506070809;
  localparam logic [7:0]  CK1 = 8'h5A;
  // Frame 2: A = 10,20..90 (0x2D0), B = nine 01 (9): 0x2D9 -> 0xD9
  localparam logic [71:0] FA2 = 72'h908070605040302010;
  localparam logic [71:0] FB2 = 72'h010101010101010101;
  localparam logic [7:0]  CK2 = 8'hD9;

  matrix_frame_loader #(
    .DATA_WIDTH    (8),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .mat_valid   (mat_valid),
    .mat_ready   (mat_ready),
    .busy        (busy),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One-cycle strobe; returns on the negedge right after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic [71:0] a, input logic [71:0] b, input logic [7:0] ck);
    for (int k = 0; k < 9; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < 9; k++) send_byte(b[8*k +: 8]);
    send_byte(ck);
  endtask

  task automatic send_frame(input logic [71:0] a, input logic [71:0] b, input logic [7:0] ck);
    send_byte(8'hA5);
    send_body(a, b, ck);
  endtask

  task automatic handshake();
    @(negedge clk);
    mat_ready = 1'b1;
    @(negedge clk);
    mat_ready = 1'b0;
  endtask

  initial begin
    logic stable;
    int   seen_at;

    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    mat_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mat_valid", {71'd0, mat_valid}, 72'd0);
    chk("rst_a_flat", a_flat, 72'd0);
    chk("rst_b_flat", b_flat, 72'd0);
    chk("rst_frame_count", {64'd0, frame_count}, 72'd0);
    chk("rst_busy_err", {68'd0, busy, err_checksum, err_timeout, err_overrun}, 72'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) basic frame, hold, handshake
    send_frame(FA1, FB1, CK1);
    chk("t1_mat_valid", {71'd0, mat_valid}, 72'd1);
    chk("t1_a0", {64'd0, a_flat[7:0]}, 72'h01);
    chk("t1_a8", {64'd0, a_flat[71:64]}, 72'h09);
    chk("t1_b0", {64'd0, b_flat[7:0]}, 72'h09);
    chk("t1_b_flat", b_flat, FB1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mat_valid !== 1'b1 || a_flat !== FA1 || b_flat !== FB1) stable = 1'b0;
    end
    chk("t1_hold_stable", {71'd0, stable}, 72'd1);
    handshake();
    chk("t1_after_hs_valid", {71'd0, mat_valid}, 72'd0);
    chk("t1_frame_count", {64'd0, frame_count}, 72'd1);

    // 2) bad checksum
    send_frame(FA1, FB1, 8'h5B);
    chk("t2_err_checksum", {71'd0, err_checksum}, 72'd1);
    chk("t2_mat_valid", {71'd0, mat_valid}, 72'd0);
    @(negedge clk);
    chk("t2_pulse_width", {71'd0, err_checksum}, 72'd0);
    chk("t2_a_unchanged", a_flat, FA1);
    chk("t2_idle", {71'd0, busy}, 72'd0);

    // 3) junk before SYNC
    send_byte(8'h00);
    send_byte(8'h33);
    chk("t3_junk_idle", {69'd0, busy, err_checksum, err_overrun}, 72'd0);
    send_frame(FA2, FB2, CK2);
    chk("t3_mat_valid", {71'd0, mat_valid}, 72'd1);
    chk("t3_a_flat", a_flat, FA2);
    chk("t3_b_flat", b_flat, FB2);
    handshake();
    chk("t3_frame_count", {64'd0, frame_count}, 72'd2);

    // 4) timeout after 3 payload bytes
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    seen_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1 && seen_at == 0) seen_at = i;
    end
    chk("t4_timeout_cycle", 72'(seen_at), 72'd16);
    chk("t4_idle", {71'd0, busy}, 72'd0);
    send_frame(FA1, FB1, CK1);
    chk("t4_mat_valid", {71'd0, mat_valid}, 72'd1);
    chk("t4_a_flat", a_flat, FA1);
    handshake();
    chk("t4_frame_count", {64'd0, frame_count}, 72'd3);

    // 5) overrun, then handshake coinciding with SYNC
    send_frame(FA2, FB2, CK2);
    send_byte(8'h11);
    chk("t5_err_overrun", {71'd0, err_overrun}, 72'd1);
    chk("t5_held_valid", {71'd0, mat_valid}, 72'd1);
    chk("t5_held_a", a_flat, FA2);
    @(negedge clk);
    rx_data   = 8'hA5;
    rx_valid  = 1'b1;
    mat_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    mat_ready = 1'b0;
    chk("t5_hs_valid", {71'd0, mat_valid}, 72'd0);
    chk("t5_hs_busy", {71'd0, busy}, 72'd1);
    chk("t5_hs_count", {64'd0, frame_count}, 72'd4);
    chk("t5_no_overrun", {71'd0, err_overrun}, 72'd0);
    send_body(FA1, FB1, CK1);
    chk("t5_frame_valid", {71'd0, mat_valid}, 72'd1);
    chk("t5_frame_a", a_flat, FA1);
    handshake();
    chk("t5_frame_count", {64'd0, frame_count}, 72'd5);

    // 6) reset mid-frame
    send_byte(8'hA5);
    for (int k = 0; k < 9; k++) send_byte(FA2[8*k +: 8]);
    send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_a", a_flat, 72'd0);
    chk("t6_rst_b", b_flat, 72'd0);
    chk("t6_rst_misc", {63'd0, frame_count, busy}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(FA2, FB2, CK2);
    chk("t6_mat_valid", {71'd0, mat_valid}, 72'd1);
    chk("t6_b_flat", b_flat, FB2);
    handshake();
    chk("t6_frame_count", {64'd0, frame_count}, 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
